// File: rtl/gpio_dbus_arb.sv
// rtl/gpio_dbus_arb.sv - round-robin arbiter of two requesters onto one GPIO register bus
// Each transaction is followed by one RECOVER cycle and is bounded by a TIMEOUT-cycle ack watchdog.
module gpio_dbus_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_w_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_w_data,
  output logic        m0_ack,
  output logic [31:0] m0_r_data,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_w_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_w_data,
  output logic        m1_ack,
  output logic [31:0] m1_r_data,
  output logic        m1_err,
  output logic        p_req,
  output logic        p_w_en,
  output logic [31:0] p_addr,
  output logic [31:0] p_w_data,
  input  logic        p_ack,
  input  logic [31:0] p_r_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            prio, gnt, sel, grant, busy, timeout, done;
  logic [CW-1:0]   cnt;
  logic            w_en_q;
  logic [31:0]     addr_q, w_data_q;
  logic            ack, err;
  logic [31:0]     r_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == BUSY);
    grant     = (state == IDLE) && (m0_req || m1_req);
    sel       = (m0_req && m1_req) ? prio : m1_req;
    timeout   = busy && (cnt == LAST);
    done      = busy && (p_ack || timeout);
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter stops at LAST because the timeout ends BUSY, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      gnt      <= 1'b0;
      cnt      <= '0;
      w_en_q   <= 1'b0;
      addr_q   <= 32'd0;
      w_data_q <= 32'd0;
    end else begin
      if (grant) begin
        gnt      <= sel;
        w_en_q   <= sel ? m1_w_en   : m0_w_en;
        addr_q   <= sel ? m1_addr   : m0_addr;
        w_data_q <= sel ? m1_w_data : m0_w_data;
        cnt      <= '0;
      end else if (busy && !done) begin
        cnt <= cnt + CW'(1);
      end
      if (done) prio <= ~gnt;
    end
  end

  // A real p_ack wins over a coincident timeout, so err needs the ack to be absent.
  always_comb begin
    ack       = done && !rst;
    err       = ack && !p_ack;
    r_data    = (ack && p_ack) ? p_r_data : 32'd0;
    m0_ack    = ack && !gnt;
    m1_ack    = ack && gnt;
    m0_err    = err && !gnt;
    m1_err    = err && gnt;
    m0_r_data = gnt ? 32'd0 : r_data;
    m1_r_data = gnt ? r_data : 32'd0;
    p_req     = busy && !rst;
    p_w_en    = w_en_q && !rst;
    p_addr    = rst ? 32'd0 : addr_q;
    p_w_data  = rst ? 32'd0 : w_data_q;
  end

endmodule

// File: tb/tb_gpio_dbus_arb.sv
// tb/tb_gpio_dbus_arb.sv - self-checking bench for gpio_dbus_arb
module tb_gpio_dbus_arb;
  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic        m0_req, m0_w_en, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_w_data, m0_r_data;
  logic        m1_req, m1_w_en, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_w_data, m1_r_data;
  logic        p_req, p_w_en, p_ack;
  logic [31:0] p_addr, p_w_data, p_r_data;

  int checks = 0;
  int errors = 0;

  gpio_dbus_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_w_en(m0_w_en), .m0_addr(m0_addr), .m0_w_data(m0_w_data),
    .m0_ack(m0_ack), .m0_r_data(m0_r_data), .m0_err(m0_err),
    .m1_req(m1_req), .m1_w_en(m1_w_en), .m1_addr(m1_addr), .m1_w_data(m1_w_data),
    .m1_ack(m1_ack), .m1_r_data(m1_r_data), .m1_err(m1_err),
    .p_req(p_req), .p_w_en(p_w_en), .p_addr(p_addr), .p_w_data(p_w_data),
    .p_ack(p_ack), .p_r_data(p_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    m0_req = 0; m0_w_en = 0; m0_addr = 0; m0_w_data = 0;
    m1_req = 0; m1_w_en = 0; m1_addr = 0; m1_w_data = 0;
    p_ack = 0; p_r_data = 0;
  endtask

  // Leaves the bench at the negedge of the first post-reset (IDLE) cycle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; m0_req = 1; m0_addr = 32'hFFFF_FFFF; p_ack = 1; p_r_data = 32'h1234_5678;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({p_req, p_w_en, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: p_req=%b p_w_en=%b acks=%b%b errs=%b%b, want all 0",
                         p_req, p_w_en, m0_ack, m1_ack, m0_err, m1_err);
    end
    checks++;
    if ({p_addr, p_w_data, m0_r_data, m1_r_data} !== 128'd0) begin
      errors++; $display("FAIL reset_data: p_addr=%h p_w_data=%h r0=%h r1=%h, want 0",
                         p_addr, p_w_data, m0_r_data, m1_r_data);
    end
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_read_single();
    do_reset();
    m0_req = 1; m0_w_en = 0; m0_addr = 32'h04; #1;
    checks++;
    if (p_req !== 1'b0) begin errors++; $display("FAIL rd_c0_preq: got %b want 0", p_req); end
    @(negedge clk); #1;
    checks++;
    if (p_req !== 1'b1 || p_addr !== 32'h04 || p_w_en !== 1'b0 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL rd_c1: p_req=%b p_addr=%h p_w_en=%b m0_ack=%b want 1/04/0/0",
                         p_req, p_addr, p_w_en, m0_ack);
    end
    @(negedge clk);
    p_ack = 1; p_r_data = 32'h0000_00A5; #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_r_data !== 32'hA5 || m1_ack !== 1'b0 || m0_err !== 1'b0) begin
      errors++; $display("FAIL rd_c2: m0_ack=%b m0_r_data=%h m1_ack=%b m0_err=%b want 1/a5/0/0",
                         m0_ack, m0_r_data, m1_ack, m0_err);
    end
    @(negedge clk);
    m0_req = 0; p_ack = 0; #1;
    checks++;
    if (p_req !== 1'b0 || m0_r_data !== 32'd0) begin
      errors++; $display("FAIL rd_recover: p_req=%b m0_r_data=%h want 0/0", p_req, m0_r_data);
    end
  endtask

  task automatic test_contention();
    int k;
    logic want;
    do_reset();
    m0_req = 1; m0_w_en = 1; m0_addr = 32'h10; m0_w_data = 32'hAAAA_0000;
    m1_req = 1; m1_w_en = 1; m1_addr = 32'h20; m1_w_data = 32'hBBBB_1111;
    for (int r = 0; r < 3; r++) begin
      want = (r == 1);
      k = 0;
      do begin
        @(negedge clk); p_ack = 0; #1; k++;
      end while (!p_req && k < 10);
      checks++;
      if (!p_req) begin errors++; $display("FAIL cont_wait round %0d: no p_req", r); end
      if (r > 0) begin
        checks++;
        if (k !== 3) begin errors++; $display("FAIL cont_gap round %0d: p_req %0d cycles after ack, want 3", r, k); end
      end
      checks++;
      if (p_addr !== (want ? 32'h20 : 32'h10) || p_w_en !== 1'b1 ||
          p_w_data !== (want ? 32'hBBBB_1111 : 32'hAAAA_0000)) begin
        errors++; $display("FAIL cont_addr round %0d: p_addr=%h p_w_data=%h p_w_en=%b want m%0d",
                           r, p_addr, p_w_data, p_w_en, want);
      end
      @(negedge clk);
      p_ack = 1; #1;
      checks++;
      if (m0_ack !== !want || m1_ack !== want || m0_err !== 1'b0 || m1_err !== 1'b0) begin
        errors++; $display("FAIL cont_ack round %0d: m0_ack=%b m1_ack=%b errs=%b%b want winner m%0d",
                           r, m0_ack, m1_ack, m0_err, m1_err, want);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    int busy_n, ack_at;
    logic e;
    logic [31:0] rd;
    do_reset();
    m1_req = 1; m1_w_en = 1; m1_addr = 32'h00; m1_w_data = 32'h3C;
    busy_n = 0; ack_at = -1; e = 0; rd = 32'hDEAD;
    for (int i = 0; i < 40 && ack_at < 0; i++) begin
      @(negedge clk); #1;
      if (p_req) busy_n++;
      if (m1_ack || m0_ack) begin ack_at = busy_n; e = m1_err; rd = m1_r_data; end
    end
    checks++;
    if (ack_at !== TIMEOUT || e !== 1'b1 || rd !== 32'd0 || p_w_data !== 32'h3C) begin
      errors++; $display("FAIL timeout: ack at busy cycle %0d err=%b r_data=%h p_w_data=%h want %0d/1/0/3c",
                         ack_at, e, rd, p_w_data, TIMEOUT);
    end
    m1_req = 0;
    @(negedge clk); #1;
    checks++;
    if (p_req !== 1'b0) begin errors++; $display("FAIL timeout_drop: p_req=%b want 0", p_req); end
  endtask

  task automatic test_ack_at_timeout();
    int busy_n;
    do_reset();
    m0_req = 1; m0_w_en = 0; m0_addr = 32'h08;
    busy_n = 0;
    for (int i = 0; i < 30 && busy_n < TIMEOUT; i++) begin
      @(negedge clk);
      if (p_req) busy_n++;
      if (busy_n == TIMEOUT) begin p_ack = 1; p_r_data = 32'h5A; end
      #1;
      if (busy_n < TIMEOUT && busy_n > 0) begin
        checks++;
        if (m0_ack !== 1'b0) begin errors++; $display("FAIL race_early: ack at busy cycle %0d", busy_n); end
      end
    end
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_r_data !== 32'h5A) begin
      errors++; $display("FAIL race: m0_ack=%b m0_err=%b m0_r_data=%h want 1/0/5a", m0_ack, m0_err, m0_r_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_in_busy();
    do_reset();
    m0_req = 1; m0_w_en = 0; m0_addr = 32'h0C;
    @(negedge clk); #1;
    checks++;
    if (p_req !== 1'b1) begin errors++; $display("FAIL rstbusy_preq: got %b want 1", p_req); end
    @(negedge clk);
    rst = 1; p_ack = 1; p_r_data = 32'h99; #1;
    checks++;
    if (m0_ack !== 1'b0 || m0_err !== 1'b0 || p_req !== 1'b0) begin
      errors++; $display("FAIL rstbusy_abort: m0_ack=%b m0_err=%b p_req=%b want 0/0/0", m0_ack, m0_err, p_req);
    end
    @(negedge clk);
    rst = 0; p_ack = 0; #1;
    checks++;
    if (p_req !== 1'b0 || m0_ack !== 1'b0) begin
      errors++; $display("FAIL rstbusy_after: p_req=%b m0_ack=%b want 0/0", p_req, m0_ack);
    end
    @(negedge clk); #1;
    checks++;
    if (p_req !== 1'b1 || p_addr !== 32'h0C) begin
      errors++; $display("FAIL rstbusy_retry: p_req=%b p_addr=%h want 1/0c", p_req, p_addr);
    end
    @(negedge clk);
    p_ack = 1; p_r_data = 32'h77; #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_r_data !== 32'h77) begin
      errors++; $display("FAIL rstbusy_serve: m0_ack=%b m0_r_data=%h want 1/77", m0_ack, m0_r_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    p_ack = 1; p_r_data = 32'hEE; #1;
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || p_req !== 1'b0) begin
      errors++; $display("FAIL spur_idle: acks=%b%b p_req=%b want 0", m0_ack, m1_ack, p_req);
    end
    @(negedge clk);
    p_ack = 0; m1_req = 1; m1_addr = 32'h30; #1;
    checks++;
    if (p_req !== 1'b0) begin errors++; $display("FAIL spur_idle_state: p_req=%b want 0", p_req); end
    @(negedge clk); #1;
    checks++;
    if (p_req !== 1'b1 || p_addr !== 32'h30) begin
      errors++; $display("FAIL spur_grant: p_req=%b p_addr=%h want 1/30", p_req, p_addr);
    end
    @(negedge clk);
    p_ack = 1; #1;
    @(negedge clk);
    m1_req = 0; p_ack = 1; #1;
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || p_req !== 1'b0) begin
      errors++; $display("FAIL spur_recover: acks=%b%b p_req=%b want 0", m0_ack, m1_ack, p_req);
    end
    @(negedge clk);
    p_ack = 0; #1;
    checks++;
    if (p_req !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL spur_recover_state: p_req=%b m1_ack=%b want 0/0", p_req, m1_ack);
    end
  endtask

  // Transaction-level model: one outstanding transfer, its owner, how many BUSY cycles it has used.
  task automatic test_random();
    bit          t_active, t_cool, t_owner, rr_next;
    int          t_age;
    bit          t_we;
    logic [31:0] t_addr, t_wd;
    bit          pend0, pend1, done, e_err, e_a0, e_a1;
    logic [31:0] e_rd;
    t_active = 0; t_cool = 0; rr_next = 0; t_age = 0; t_owner = 0;
    t_we = 0; t_addr = 0; t_wd = 0; pend0 = 0; pend1 = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!pend0 && $urandom_range(3) == 0) begin
        pend0 = 1; m0_w_en = 1'($urandom); m0_addr = $urandom; m0_w_data = $urandom;
      end
      if (!pend1 && $urandom_range(3) == 0) begin
        pend1 = 1; m1_w_en = 1'($urandom); m1_addr = $urandom; m1_w_data = $urandom;
      end
      m0_req = pend0 && !(t_active && t_owner == 0 && $urandom_range(7) == 0);
      m1_req = pend1 && !(t_active && t_owner == 1 && $urandom_range(7) == 0);
      rst = (i == 0) || ($urandom_range(79) == 0);
      if (t_active) p_ack = (t_age >= 1) && ($urandom_range(5) == 0);
      else          p_ack = ($urandom_range(7) == 0);
      p_r_data = $urandom;
      #1;
      done  = !rst && t_active && (p_ack || (t_age + 1 == TIMEOUT));
      e_err = done && !p_ack;
      e_a0  = done && t_owner == 0;
      e_a1  = done && t_owner == 1;
      e_rd  = (done && p_ack) ? p_r_data : 32'd0;
      checks++;
      if (p_req !== (t_active && !rst) || m0_ack !== e_a0 || m1_ack !== e_a1 ||
          m0_err !== (e_err && !t_owner) || m1_err !== (e_err && t_owner)) begin
        errors++; $display("FAIL rand_ctrl cyc %0d: p_req=%b acks=%b%b errs=%b%b want %b %b%b %b%b",
                           i, p_req, m0_ack, m1_ack, m0_err, m1_err, t_active && !rst,
                           e_a0, e_a1, e_err && !t_owner, e_err && t_owner);
      end
      checks++;
      if ((!e_a0 || !t_we) && m0_r_data !== (e_a0 ? e_rd : 32'd0) ||
          (!e_a1 || !t_we) && m1_r_data !== (e_a1 ? e_rd : 32'd0)) begin
        errors++; $display("FAIL rand_rdata cyc %0d: r0=%h r1=%h owner=m%0d want %h to owner only",
                           i, m0_r_data, m1_r_data, t_owner, e_rd);
      end
      if (rst || t_active) begin
        checks++;
        if (rst ? ({p_w_en, p_addr, p_w_data} !== 65'd0)
                : ({p_w_en, p_addr, p_w_data} !== {t_we, t_addr, t_wd})) begin
          errors++; $display("FAIL rand_bus cyc %0d: we=%b addr=%h wd=%h want %b/%h/%h (rst=%b)",
                             i, p_w_en, p_addr, p_w_data, t_we, t_addr, t_wd, rst);
        end
      end
      if (e_a0) pend0 = 0;
      if (e_a1) pend1 = 0;
      if (rst) begin
        t_active = 0; t_cool = 0; rr_next = 0; t_age = 0;
      end else if (t_active) begin
        if (done) begin t_active = 0; t_cool = 1; rr_next = !t_owner; end
        else t_age++;
      end else if (t_cool) begin
        t_cool = 0;
      end else if (m0_req || m1_req) begin
        t_active = 1; t_age = 0;
        t_owner = (m0_req && m1_req) ? rr_next : m1_req;
        t_we   = t_owner ? m1_w_en   : m0_w_en;
        t_addr = t_owner ? m1_addr   : m0_addr;
        t_wd   = t_owner ? m1_w_data : m0_w_data;
      end
    end
    @(negedge clk);
    clear_inputs();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_read_single();
    test_contention();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_busy();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
